// File: rtl/cache_line_pkg.sv
// Shared state encoding, write-length codes and sizing helpers for the
// multi-port cache line.
package cache_line_pkg;

    typedef enum logic [2:0] {
        INVALID,
        READY,
        FLUSH,
        FILL_REQ,
        FILL_WAIT
    } state_t;

    localparam logic [1:0] WL_BYTE = 2'b00;
    localparam logic [1:0] WL_HALF = 2'b01;
    localparam logic [1:0] WL_WORD = 2'b10;

    function automatic int calc_words(input int lsbbits);
        return 1 << (lsbbits - 2);
    endfunction

    function automatic int calc_maxttl(input int ttlbits);
        return (1 << ttlbits) - 1;
    endfunction

endpackage

// File: rtl/cache_line_bytemerge.sv
// Merges byte/half/word write data into an existing 32-bit word and flags
// whether the access is naturally aligned.
module cache_line_bytemerge
    import cache_line_pkg::*;
(
    input  logic [31:0] i_old,
    input  logic [31:0] i_data,
    input  logic [1:0]  i_addr,
    input  logic [1:0]  i_wordlen,
    output logic [31:0] o_word,
    output logic        o_aligned
);

    // NOTE: both outputs get a default before the case so no path leaves them unassigned (no latch).
    always_comb begin
        o_word    = i_old;
        o_aligned = 1'b1;
        case (i_wordlen)
            WL_BYTE: begin
                o_word[{i_addr, 3'b000} +: 8] = i_data[7:0];
            end
            WL_HALF: begin
                o_aligned = ~i_addr[0];
                o_word[{i_addr[1], 4'b0000} +: 16] = i_data[15:0];
            end
            default: begin
                o_aligned = (i_addr == 2'b00);
                o_word    = i_data;
            end
        endcase
    end

endmodule

// File: rtl/cache_line_mp.sv
// Multi-port register-based cache line with one write port and its own
// flush/refill sequencing against a single-word memory port.
module cache_line_mp
    import cache_line_pkg::*;
#(
    parameter int ADDRBITS    = 32,
    parameter int DATABITS    = 32,
    parameter int LSBBITS     = 7,
    parameter int NRDPORTS    = 2,
    parameter int TTLBITS     = 8,
    parameter int WORDLENBITS = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NRDPORTS*ADDRBITS-1:0] line_rdaddr,
    input  logic [NRDPORTS-1:0]          line_rdreq,
    output logic [NRDPORTS*DATABITS-1:0] line_out,
    output logic [NRDPORTS-1:0]          line_out_valid,
    input  logic [ADDRBITS-1:0]          line_wraddr,
    input  logic [DATABITS-1:0]          line_in,
    input  logic [WORDLENBITS-1:0]       line_in_wordlen,
    input  logic                         line_wrreq,
    output logic                         line_dirty,
    output logic                         line_miss,
    input  logic                         line_flush,
    input  logic                         line_fill,
    input  logic                         line_pause,
    output logic [TTLBITS-1:0]           line_ttl,
    input  logic [ADDRBITS-1:0]          new_region,
    output logic                         line_ready,
    output logic [ADDRBITS-1:0]          mem_addr,
    output logic [DATABITS-1:0]          mem_in,
    input  logic [DATABITS-1:0]          mem_out,
    input  logic                         mem_out_valid,
    output logic                         mem_wrreq,
    output logic                         mem_rdreq
);

    localparam int WORDS   = calc_words(LSBBITS);
    localparam int KBITS   = LSBBITS - 2;
    localparam int TAGBITS = ADDRBITS - LSBBITS;
    localparam logic [TTLBITS-1:0] MAXTTL = TTLBITS'(calc_maxttl(TTLBITS));
    localparam logic [KBITS-1:0]   LAST_K = KBITS'(WORDS - 1);

    state_t                       r_state;
    logic                         r_ready;
    logic                         r_valid;
    logic                         r_dirty;
    logic                         r_fill_pend;
    logic [TAGBITS-1:0]           r_tag;
    logic [TAGBITS-1:0]           r_new_tag;
    logic [KBITS-1:0]             r_k;
    logic [DATABITS-1:0]          r_words [WORDS];
    logic [TTLBITS-1:0]           r_ttl;
    logic                         r_miss;
    logic [NRDPORTS*DATABITS-1:0] r_line_out;
    logic [NRDPORTS-1:0]          r_line_out_valid;
    logic [ADDRBITS-1:0]          r_mem_addr;
    logic [DATABITS-1:0]          r_mem_in;
    logic                         r_mem_wrreq;
    logic                         r_mem_rdreq;

    logic                         w_serving;
    logic [NRDPORTS-1:0]          w_rd_hit;
    logic [KBITS-1:0]             w_rd_idx [NRDPORTS];
    logic [KBITS-1:0]             w_wr_idx;
    logic [DATABITS-1:0]          w_wr_word;
    logic                         w_wr_aligned;
    logic                         w_wr_hit;
    logic                         w_any_req;
    logic                         w_any_hit;
    logic                         w_dirty_now;
    logic [TAGBITS-1:0]           w_region_tag;
    logic                         w_unused;

    assign w_serving    = r_valid && (r_state == READY);
    assign w_region_tag = new_region[ADDRBITS-1:LSBBITS];

    always_comb begin
        w_unused = ^new_region[LSBBITS-1:0];
        for (int i = 0; i < NRDPORTS; i++) begin
            w_rd_idx[i] = line_rdaddr[i*ADDRBITS + 2 +: KBITS];
            w_rd_hit[i] = line_rdreq[i] && w_serving &&
                          (line_rdaddr[i*ADDRBITS + LSBBITS +: TAGBITS] == r_tag);
            w_unused    = w_unused ^ (^line_rdaddr[i*ADDRBITS +: 2]);
        end
    end

    assign w_wr_idx = line_wraddr[LSBBITS-1:2];

    cache_line_bytemerge u_bytemerge (
        .i_old      (r_words[w_wr_idx]),
        .i_data     (line_in),
        .i_addr     (line_wraddr[1:0]),
        .i_wordlen  (line_in_wordlen),
        .o_word     (w_wr_word),
        .o_aligned  (w_wr_aligned)
    );

    assign w_wr_hit    = line_wrreq && w_serving && w_wr_aligned &&
                         (line_wraddr[ADDRBITS-1:LSBBITS] == r_tag);
    assign w_any_req   = line_wrreq || (|line_rdreq);
    assign w_any_hit   = w_wr_hit || (|w_rd_hit);
    // A write landing in the same cycle as a command must still be flushed.
    assign w_dirty_now = r_dirty || w_wr_hit;

    // NOTE: line storage is deliberately not reset; r_valid and r_state alone qualify its contents.
    always_ff @(posedge clk) begin
        if (r_state == FILL_WAIT && mem_out_valid) begin
            r_words[r_k] <= mem_out;
        end else if (w_wr_hit) begin
            r_words[w_wr_idx] <= w_wr_word;
        end
    end

    // NOTE: every sequential block uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= INVALID;
            r_ready     <= 1'b0;
            r_valid     <= 1'b0;
            r_dirty     <= 1'b0;
            r_fill_pend <= 1'b0;
            r_tag       <= '0;
            r_new_tag   <= '0;
            r_k         <= '0;
            r_mem_addr  <= '0;
            r_mem_in    <= '0;
            r_mem_wrreq <= 1'b0;
            r_mem_rdreq <= 1'b0;
        end else begin
            r_mem_wrreq <= 1'b0;
            r_mem_rdreq <= 1'b0;
            if (w_wr_hit) begin
                r_dirty <= 1'b1;
            end
            case (r_state)
                INVALID, READY: begin
                    r_ready <= 1'b1;
                    if (r_ready && (line_flush || line_fill)) begin
                        r_new_tag   <= w_region_tag;
                        r_fill_pend <= line_fill;
                        r_k         <= '0;
                        if (w_dirty_now) begin
                            r_state <= FLUSH;
                            r_ready <= 1'b0;
                            r_valid <= 1'b0;
                        end else if (line_fill) begin
                            r_state <= FILL_REQ;
                            r_ready <= 1'b0;
                            r_valid <= 1'b0;
                            r_tag   <= w_region_tag;
                        end else begin
                            r_state <= INVALID;
                            r_valid <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    if (!line_pause) begin
                        r_mem_wrreq <= 1'b1;
                        r_mem_addr  <= {r_tag, r_k, 2'b00};
                        r_mem_in    <= r_words[r_k];
                        r_k         <= r_k + 1'b1;
                        if (r_k == LAST_K) begin
                            r_dirty <= 1'b0;
                            if (r_fill_pend) begin
                                r_state <= FILL_REQ;
                                r_tag   <= r_new_tag;
                            end else begin
                                r_state <= INVALID;
                                r_ready <= 1'b1;
                            end
                        end
                    end
                end
                FILL_REQ: begin
                    if (!line_pause) begin
                        r_mem_rdreq <= 1'b1;
                        r_mem_addr  <= {r_tag, r_k, 2'b00};
                        r_state     <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    if (mem_out_valid) begin
                        r_k <= r_k + 1'b1;
                        if (r_k == LAST_K) begin
                            r_state <= READY;
                            r_valid <= 1'b1;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= FILL_REQ;
                        end
                    end
                end
                default: begin
                    r_state <= INVALID;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_miss           <= 1'b0;
            r_line_out       <= '0;
            r_line_out_valid <= '0;
            r_ttl            <= '0;
        end else begin
            r_miss <= w_any_req && !w_any_hit;
            for (int i = 0; i < NRDPORTS; i++) begin
                r_line_out_valid[i] <= w_rd_hit[i];
                if (w_rd_hit[i]) begin
                    r_line_out[i*DATABITS +: DATABITS] <= r_words[w_rd_idx[i]];
                end
            end
            if (r_state != READY) begin
                r_ttl <= '0;
            end else if (w_any_hit) begin
                r_ttl <= MAXTTL;
            end else if (r_ttl != '0) begin
                r_ttl <= r_ttl - 1'b1;
            end
        end
    end

    assign line_out       = r_line_out;
    assign line_out_valid = r_line_out_valid;
    assign line_dirty     = r_dirty;
    assign line_miss      = r_miss;
    assign line_ttl       = r_ttl;
    assign line_ready     = r_ready;
    assign mem_addr       = r_mem_addr;
    assign mem_in         = r_mem_in;
    assign mem_wrreq      = r_mem_wrreq;
    assign mem_rdreq      = r_mem_rdreq;

endmodule

// File: tb/tb_cache_line_mp.sv
// Directed scoreboard bench for cache_line_mp: fill, dual reads, merges,
// paused flush+refill, miss/ttl ageing and reset during refill.
module tb_cache_line_mp;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] line_rdaddr = '0;
    logic [1:0]  line_rdreq = '0;
    logic [63:0] line_out;
    logic [1:0]  line_out_valid;
    logic [31:0] line_wraddr = '0;
    logic [31:0] line_in = '0;
    logic [1:0]  line_in_wordlen = '0;
    logic        line_wrreq = 1'b0;
    logic        line_dirty;
    logic        line_miss;
    logic        line_flush = 1'b0;
    logic        line_fill = 1'b0;
    logic        line_pause = 1'b0;
    logic [7:0]  line_ttl;
    logic [31:0] new_region = '0;
    logic        line_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_in;
    logic [31:0] mem_out = '0;
    logic        mem_out_valid = 1'b0;
    logic        mem_wrreq;
    logic        mem_rdreq;

    cache_line_mp dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .line_rdaddr     (line_rdaddr),
        .line_rdreq      (line_rdreq),
        .line_out        (line_out),
        .line_out_valid  (line_out_valid),
        .line_wraddr     (line_wraddr),
        .line_in         (line_in),
        .line_in_wordlen (line_in_wordlen),
        .line_wrreq      (line_wrreq),
        .line_dirty      (line_dirty),
        .line_miss       (line_miss),
        .line_flush      (line_flush),
        .line_fill       (line_fill),
        .line_pause      (line_pause),
        .line_ttl        (line_ttl),
        .new_region      (new_region),
        .line_ready      (line_ready),
        .mem_addr        (mem_addr),
        .mem_in          (mem_in),
        .mem_out         (mem_out),
        .mem_out_valid   (mem_out_valid),
        .mem_wrreq       (mem_wrreq),
        .mem_rdreq       (mem_rdreq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  vld;
        logic [63:0] data;
        logic        miss;
    } rd_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_exp_t;

    rd_exp_t     q_rd[$];
    wr_exp_t     q_wr[$];
    logic [31:0] q_fill[$];
    logic [31:0] exp_line [32];

    int n_checks = 0;
    int n_pass   = 0;
    int n_wr     = 0;
    int n_rd     = 0;
    int n_gap    = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0fff0000 | {27'd0, a[6:2]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives a read (and whatever write is already set up) for one cycle and
    // compares the registered result against the queued expectation.
    task automatic do_read(input string tag, input logic [1:0] req,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [1:0] vld, input logic [63:0] data,
                           input logic miss);
        rd_exp_t e;
        q_rd.push_back('{vld: vld, data: data, miss: miss});
        line_rdaddr = {a1, a0};
        line_rdreq  = req;
        @(negedge clk);
        line_rdreq = '0;
        line_wrreq = 1'b0;
        e = q_rd.pop_front();
        check({tag, "_vld"}, line_out_valid, e.vld);
        check({tag, "_data"}, line_out, e.data);
        check({tag, "_miss"}, line_miss, e.miss);
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] wl, input logic miss);
        line_wraddr     = a;
        line_in         = d;
        line_in_wordlen = wl;
        line_wrreq      = 1'b1;
        @(negedge clk);
        line_wrreq = 1'b0;
        check({tag, "_miss"}, line_miss, miss);
    endtask

    // Acts as memory until the line reports ready again; pauses for five
    // cycles once pause_at writes have been seen.
    task automatic service_mem(input int budget, input int pause_at);
        int cyc = 0;
        int pcnt = 0;
        wr_exp_t w;
        n_wr  = 0;
        n_rd  = 0;
        n_gap = 0;
        while (!line_ready && cyc < budget) begin
            @(negedge clk);
            cyc++;
            mem_out_valid = 1'b0;
            if (mem_wrreq) begin
                check("wr_expected", q_wr.size() != 0, 1'b1);
                if (q_wr.size() != 0) begin
                    w = q_wr.pop_front();
                    check("flush_addr", mem_addr, w.addr);
                    check("flush_data", mem_in, w.data);
                end
                n_wr++;
                if (n_wr == pause_at) pcnt = 5;
            end else if (n_wr > 0 && n_wr < 32) begin
                n_gap++;
            end
            if (mem_rdreq) begin
                check("rd_expected", q_fill.size() != 0, 1'b1);
                if (q_fill.size() != 0) check("fill_addr", mem_addr, q_fill.pop_front());
                mem_out       = mem_word(mem_addr);
                mem_out_valid = 1'b1;
                n_rd++;
            end
            if (pcnt > 0) begin
                line_pause = 1'b1;
                pcnt--;
            end else begin
                line_pause = 1'b0;
            end
        end
        mem_out_valid = 1'b0;
        line_pause    = 1'b0;
        check("svc_ready", line_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_ctrl", {line_ready, line_dirty, line_miss, mem_wrreq, mem_rdreq, line_out_valid}, 0);
        check("rst_ttl", line_ttl, 0);
        check("rst_mem", {mem_addr, mem_in}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", line_ready, 1'b1);

        // Refill region 0x80000000; low bits of new_region must be ignored.
        for (int k = 0; k < 32; k++) begin
            exp_line[k] = mem_word(32'(k * 4));
            q_fill.push_back(32'h80000000 + 32'(k * 4));
        end
        line_fill  = 1'b1;
        new_region = 32'h80000045;
        @(negedge clk);
        line_fill = 1'b0;
        check("fill_busy", line_ready, 1'b0);
        service_mem(200, 0);
        check("fill_rd_count", n_rd, 32);
        check("fill_dirty", line_dirty, 1'b0);
        check("fill_ttl_idle", line_ttl, 0);

        // Both ports in the same cycle.
        do_read("dual", 2'b11, 32'h80000004, 32'h8000007c, 2'b11, {32'h0fff001f, 32'h0fff0001}, 1'b0);
        check("dual_ttl", line_ttl, 255);

        // Byte, half and word merges, including misaligned misses.
        do_write("wb_ab", 32'h80000009, 32'h000000ab, 2'b00, 1'b0);
        exp_line[2] = 32'h0fffab02;
        check("wb_dirty", line_dirty, 1'b1);
        line_wraddr = 32'h8000000a; line_in = 32'h000000cd; line_in_wordlen = 2'b00; line_wrreq = 1'b1;
        do_read("rd_prewrite", 2'b01, 32'h80000008, 32'h0, 2'b01, {32'h0fff001f, 32'h0fffab02}, 1'b0);
        exp_line[2] = 32'h0fcdab02;
        do_write("wh_misalign", 32'h80000009, 32'h0000beef, 2'b01, 1'b1);
        do_read("rd_after_miss", 2'b10, 32'h0, 32'h80000008, 2'b10, {32'h0fcdab02, 32'h0fffab02}, 1'b0);
        do_write("wh_upper", 32'h80000012, 32'h00001234, 2'b01, 1'b0);
        exp_line[4] = 32'h12340004;
        do_write("ww_misalign", 32'h80000011, 32'hdeadbeef, 2'b10, 1'b1);
        do_write("ww_aligned", 32'h80000040, 32'hcafef00d, 2'b11, 1'b0);
        exp_line[16] = 32'hcafef00d;
        do_read("rd_merged", 2'b11, 32'h80000010, 32'h80000040, 2'b11, {32'hcafef00d, 32'h12340004}, 1'b0);

        // Flush+refill to a new region with a 5-cycle pause mid-flush.
        for (int k = 0; k < 32; k++) begin
            q_wr.push_back('{addr: 32'h80000000 + 32'(k * 4), data: exp_line[k]});
            q_fill.push_back(32'h12345600 + 32'(k * 4));
        end
        line_flush = 1'b1;
        line_fill  = 1'b1;
        new_region = 32'h12345678;
        @(negedge clk);
        line_flush = 1'b0;
        line_fill  = 1'b0;
        check("ff_busy", line_ready, 1'b0);
        service_mem(400, 10);
        check("ff_wr_count", n_wr, 32);
        check("ff_gap", n_gap, 5);
        check("ff_rd_count", n_rd, 32);
        check("ff_dirty", line_dirty, 1'b0);
        do_read("rd_newtag", 2'b11, 32'h12345604, 32'h12345678, 2'b11, {32'h0fff001e, 32'h0fff0001}, 1'b0);
        check("newtag_ttl", line_ttl, 255);

        // Miss in READY, then TTL ageing and saturation.
        do_read("rd_miss", 2'b01, 32'h90000000, 32'h0, 2'b00, {32'h0fff001e, 32'h0fff0001}, 1'b1);
        check("miss_ttl", line_ttl, 254);
        repeat (253) @(negedge clk);
        check("ttl_one", line_ttl, 1);
        @(negedge clk);
        check("ttl_zero", line_ttl, 0);
        repeat (5) @(negedge clk);
        check("ttl_sat", line_ttl, 0);
        check("miss_pulse_end", line_miss, 1'b0);

        // Async reset while waiting for refill data.
        line_fill  = 1'b1;
        new_region = 32'h80000000;
        @(negedge clk);
        line_fill = 1'b0;
        n = 0;
        for (int c = 0; c < 100 && n < 4; c++) begin
            @(negedge clk);
            mem_out_valid = 1'b0;
            if (mem_rdreq) begin
                n++;
                if (n < 4) begin
                    mem_out       = mem_word(mem_addr);
                    mem_out_valid = 1'b1;
                end
            end
        end
        check("rst_wait_reached", n, 4);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_ctrl", {line_ready, line_dirty, line_miss, mem_wrreq, mem_rdreq, line_out_valid}, 0);
        check("midrst_out", line_out, 0);
        check("midrst_mem", {mem_addr, mem_in}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_ready", line_ready, 1'b1);
        do_read("rd_after_rst", 2'b01, 32'h80000000, 32'h0, 2'b00, 64'h0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
